// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared definitions for the serial pattern detector:
//               FSM state encoding, pattern geometry and length clamping.
// Contents    : state_t   - serialiser FSM states
//               PAT_W     - pattern / history width in bits
//               LEN_MIN   - shortest supported pattern length
//               LEN_MAX   - longest supported pattern length
//               clamp_len - maps a requested length into [LEN_MIN, LEN_MAX]
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam int PAT_W   = 8;
  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'(LEN_MIN)) begin
      return 4'(LEN_MIN);
    end else if (len > 4'(LEN_MAX)) begin
      return 4'(LEN_MAX);
    end
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pat_match.sv
`default_nettype none
// ============================================================================
// Module      : pat_match
// Description : Bit-history matcher. Keeps the most recent PAT_W bits of the
//               current frame plus a saturating fill count, and flags a match
//               on the bit being shifted in this cycle.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               shift_en    - a new bit is shifted in at this edge
//               shift_bit   - the bit being shifted in
//               frame_end   - this bit closes the frame; clear afterwards
//               pattern     - target pattern, bit 0 = most recent bit
//               len         - pattern length, already clamped to 2..8
//               match       - combinational: the shift at this edge completes
//                             a match
// Revision    : 1.0 - initial release
// ============================================================================
module pat_match
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             shift_bit,
  input  logic             frame_end,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  output logic             match
);

  logic [PAT_W-1:0] r_hist;
  logic [3:0]       r_fill;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [3:0]       w_fill_nxt;
  logic [PAT_W-1:0] w_mask;

  // The compare looks at the history as it will be after this shift, so the
  // final bit of a frame can still complete a match before the clear.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], shift_bit};
    w_fill_nxt = (r_fill >= 4'(LEN_MAX)) ? 4'(LEN_MAX) : r_fill + 4'd1;
    w_mask     = {PAT_W{1'b1}} >> (4'(PAT_W) - len);
    match      = shift_en && (w_fill_nxt >= len) &&
                 ((w_hist_nxt & w_mask) == (pattern & w_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      if (frame_end) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_nxt;
        r_fill <= w_fill_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Serial bit-pattern detector. Bytes accepted on a valid/ready
//               handshake are serialised MSB first, one bit per cycle, into a
//               pattern matcher. Matches are pulsed, counted (saturating) and
//               raise a sticky interrupt when the count reaches a threshold.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               cfg_we           - config write (taken only when idle and
//                                  s_valid is low)
//               cfg_pattern      - target pattern, bit 0 = most recent bit
//               cfg_len          - pattern length, clamped to 2..8
//               cfg_threshold    - irq threshold, 0 disables irq
//               s_valid/s_ready  - byte handshake
//               s_data, s_last   - byte and end-of-frame marker
//               cnt_clr, irq_clr - clear match_count / irq
//               match_pulse      - one cycle per match
//               match_count      - saturating match counter
//               irq              - sticky threshold flag
//               busy             - serialiser active
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              cnt_clr,
  input  logic              irq_clr,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  output logic              busy
);

  localparam int c_IDX_W = $clog2(DATA_W);

  state_t              r_state;
  logic [DATA_W-1:0]   r_byte;
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_last;

  logic [PAT_W-1:0]    r_pattern;
  logic [3:0]          r_len;
  logic [CNT_W-1:0]    r_threshold;

  logic                w_hs;
  logic                w_shift;
  logic                w_bit;
  logic                w_frame_end;
  logic                w_match;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_irq_set;

  assign w_hs        = s_valid && s_ready;
  assign w_shift     = (r_state == ST_SHIFT);
  assign w_bit       = r_byte[r_idx];
  assign w_frame_end = w_shift && (r_idx == '0) && r_last;

  // Serialiser FSM. s_ready and busy are registered from the next-state
  // decision; s_ready reopens in the cycle presenting bit 0 so a following
  // byte is taken on the same edge that shifts that bit, leaving no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_byte  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_state <= ST_SHIFT;
            r_byte  <= s_data;
            r_last  <= s_last;
            r_idx   <= c_IDX_W'(DATA_W - 1);
            s_ready <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_idx == '0) begin
            if (w_hs) begin
              r_byte  <= s_data;
              r_last  <= s_last;
              r_idx   <= c_IDX_W'(DATA_W - 1);
              s_ready <= 1'b0;
              busy    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end
          end else begin
            r_idx   <= r_idx - 1'b1;
            s_ready <= (r_idx == c_IDX_W'(1));
          end
        end
        default: begin
          r_state <= ST_IDLE;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Configuration only changes while nothing is in flight or being offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern   <= 8'h09;
      r_len       <= 4'd4;
      r_threshold <= '0;
    end else if (cfg_we && (r_state == ST_IDLE) && !s_valid) begin
      r_pattern   <= cfg_pattern;
      r_len       <= clamp_len(cfg_len);
      r_threshold <= cfg_threshold;
    end
  end

  pat_match u_pat_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (w_shift),
    .shift_bit (w_bit),
    .frame_end (w_frame_end),
    .pattern   (r_pattern),
    .len       (r_len),
    .match     (w_match)
  );

  // Clear beats a coincident match; the counter holds at all-ones.
  always_comb begin
    w_cnt_nxt = match_count;
    if (cnt_clr) begin
      w_cnt_nxt = '0;
    end else if (w_match && (match_count != {CNT_W{1'b1}})) begin
      w_cnt_nxt = match_count + CNT_W'(1);
    end
  end

  // irq fires only on the transition into the threshold value, so a
  // saturated or held count does not re-arm it after irq_clr.
  assign w_irq_set = (w_cnt_nxt != match_count) &&
                     (w_cnt_nxt == r_threshold) &&
                     (r_threshold != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_pulse <= 1'b0;
      match_count <= '0;
      irq         <= 1'b0;
    end else begin
      match_pulse <= w_match;
      match_count <= w_cnt_nxt;
      if (w_irq_set) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, meaning byte width serialised per transfer (fixed at 8 for this release).
REQ-002 Parameter CNT_W, default 8, meaning match counter width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_pattern  input  8  target bit pattern, LSB-aligned (bit 0 = most recent bit).
REQ-007 cfg_len  input  4  pattern length in bits.
REQ-008 cfg_threshold  input  CNT_W  match count that raises irq; 0 disables irq.
REQ-009 s_valid / s_ready  input / output  1 / 1  byte handshake.
REQ-010 s_data  input  8  byte, serialised MSB first.
REQ-011 s_last  input  1  final byte of frame.
REQ-012 cnt_clr / irq_clr  input  1 / 1  clear match_count / clear irq.
REQ-013 match_pulse  output  1  one-cycle match indication.
REQ-014 match_count  output  CNT_W  saturating match count.
REQ-015 irq / busy  output  1 / 1  sticky threshold flag / serialiser active.

Function
REQ-016 FSM states IDLE and SHIFT: IDLE->SHIFT on handshake; SHIFT->IDLE after bit 0 when no new handshake; SHIFT->SHIFT on handshake during the bit-0 cycle.
REQ-017 s_ready SHALL be 1 in IDLE and in the SHIFT cycle presenting bit 0; 0 otherwise.
REQ-018 Handshake at edge E0 SHALL shift bit 7 into the history register at E1, bit 6 at E2, ... bit 0 at E8; back-to-back bytes give one bit per cycle without gaps.
REQ-019 busy SHALL be 1 exactly while in SHIFT.
REQ-020 Matcher SHALL keep an 8-bit history and a fill count saturating at 8; match when fill >= len and history[len-1:0] == pattern[len-1:0].
REQ-021 Overlapping matches SHALL be counted (history not cleared on match).
REQ-022 After bit 0 of an s_last byte is shifted, history and fill SHALL clear; matches never span frames.
REQ-023 match_pulse SHALL be high in the cycle immediately after the edge that shifted the completing bit, for one cycle per match.
REQ-024 match_count SHALL increment on each match, saturating at 2^CNT_W-1.
REQ-025 cnt_clr SHALL zero match_count; cnt_clr coincident with a match: clear wins, that match is not counted.
REQ-026 irq SHALL set when match_count transitions to equal cfg_threshold (threshold != 0) and hold until irq_clr; coincident set and irq_clr: set wins.
REQ-027 cfg_we SHALL be accepted only in IDLE with s_valid low; otherwise ignored, config registers unchanged.
REQ-028 cfg_len below 2 SHALL be stored as 2; above 8 stored as 8.

Reset
REQ-029 rst_n low SHALL force IDLE, history=0, fill=0, match_count=0, irq=0, match_pulse=0, busy=0, s_ready=1 once deasserted.
REQ-030 Config registers SHALL reset to pattern=0x09, len=4, threshold=0.
REQ-031 Reset mid-byte SHALL abandon the byte; no partial match reported after release.

Structure
REQ-032 Shared package seq_det_pkg SHALL hold the state enum, PAT_W=8, LEN_MIN=2, LEN_MAX=8.
REQ-033 Sub-module pat_match SHALL contain history, fill counter and compare; seq_det_ctrl holds FSM, serialiser, config, counter, irq.

Verification
REQ-034 Pattern 0x09/len 4, byte 0x99 s_last=1 -> two match_pulses (after bits 4 and 0), match_count=2.
REQ-035 Pattern 0x05/len 3, byte 0xAA -> three overlapping matches, match_count=3.
REQ-036 Pattern 0x09/len 4, bytes 0x04 then 0x80 with s_last=0 on first -> 1 match; repeat with s_last=1 on first -> 0 matches.
REQ-037 Threshold 2, pattern 0x05/len 3, byte 0xAA -> irq rises with second match_pulse, count reaches 3, irq held until irq_clr.
REQ-038 Back-to-back bytes with s_valid held high -> s_ready high only on bit-0 cycles, busy continuous, 8 cycles per byte.
REQ-039 rst_n asserted at bit 3 of 0x99 -> all outputs at reset values, next byte 0x09 s_last=1 yields exactly 1 match.
